// File: rtl/core_bus_port.sv
// core_bus_port: core-side bus initiator; queues core ops and drives one bus request at a time.
// Define BUS_TIMEOUT_EN to abort requests left ungranted for TIMEOUT_CYCLES cycles.
module core_bus_port #(
  parameter int DEPTH          = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic       op_rw,
  input  logic [7:0] op_address,
  input  logic [7:0] op_wdata,
  output logic       resp_valid,
  output logic [7:0] resp_rdata,
  output logic       resp_error,
  output logic       bus_request,
  output logic       bus_rw,
  output logic [7:0] bus_address,
  output logic [7:0] bus_data_out,
  input  logic [7:0] bus_data_in,
  input  logic       bus_grant
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t        state_q, state_d;
  logic [16:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          bus_request_q, bus_request_d, bus_rw_q, bus_rw_d;
  logic [7:0]    bus_address_q, bus_address_d, bus_data_out_q, bus_data_out_d;
  logic          resp_valid_q, resp_valid_d, resp_error_q, resp_error_d;
  logic [7:0]    resp_rdata_q, resp_rdata_d;
  logic          push, pop, abort;
  assign op_ready     = count_q != (AW+1)'(DEPTH);
  assign push         = op_valid && op_ready;
  assign bus_request  = bus_request_q;
  assign bus_rw       = bus_rw_q;
  assign bus_address  = bus_address_q;
  assign bus_data_out = bus_data_out_q;
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_error   = resp_error_q;
`ifdef BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmr_q, tmr_d;
  assign tmr_d = (state_q == REQ) ? tmr_q + TW'(1) : '0;
  assign abort = (state_q == REQ) && !bus_grant && (tmr_q == TW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk)
    tmr_q <= reset ? '0 : tmr_d;
`else
  assign abort = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif
  always_comb begin
    state_d        = state_q;
    bus_request_d  = bus_request_q;
    bus_rw_d       = bus_rw_q;
    bus_address_d  = bus_address_q;
    bus_data_out_d = bus_data_out_q;
    resp_valid_d   = 1'b0;
    resp_rdata_d   = resp_rdata_q;
    resp_error_d   = resp_error_q;
    pop            = 1'b0;
    case (state_q)
      IDLE: if (count_q != '0) begin
        state_d       = REQ;
        bus_request_d = 1'b1;
        {bus_rw_d, bus_address_d, bus_data_out_d} = mem_q[rd_ptr_q];
      end
      REQ: if (bus_grant || abort) begin
        state_d       = DONE;
        bus_request_d = 1'b0;
        pop           = 1'b1;
        resp_valid_d  = 1'b1;
        resp_rdata_d  = (bus_grant && bus_rw_q) ? bus_data_in : 8'h00;
        resp_error_d  = abort;
      end
      default: state_d = IDLE;
    endcase
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= {op_rw, op_address, op_wdata};
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      bus_request_q  <= 1'b0;
      bus_rw_q       <= 1'b0;
      bus_address_q  <= '0;
      bus_data_out_q <= '0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= '0;
      resp_error_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_q       <= pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_q        <= count_d;
      bus_request_q  <= bus_request_d;
      bus_rw_q       <= bus_rw_d;
      bus_address_q  <= bus_address_d;
      bus_data_out_q <= bus_data_out_d;
      resp_valid_q   <= resp_valid_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_error_q   <= resp_error_d;
    end
  end
endmodule

// File: tb/tb_core_bus_port.sv
// tb_core_bus_port: directed table + random traffic against a queue-based behavioural model.
module tb_core_bus_port;
  localparam int DEPTH = 2;
  localparam int TMO   = 8;
  logic       clk = 0, reset = 1, op_valid = 0, op_rw = 0, bus_grant = 0;
  logic [7:0] op_address = 0, op_wdata = 0, bus_data_in = 0;
  logic       op_ready, resp_valid, resp_error, bus_request, bus_rw;
  logic [7:0] resp_rdata, bus_address, bus_data_out;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  core_bus_port #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready), .op_rw(op_rw),
    .op_address(op_address), .op_wdata(op_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_error(resp_error), .bus_request(bus_request),
    .bus_rw(bus_rw), .bus_address(bus_address), .bus_data_out(bus_data_out),
    .bus_data_in(bus_data_in), .bus_grant(bus_grant)
  );
  function automatic void chk(input string n, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", n, a, e, $time);
    end
  endfunction
  // Model: the pending ops are a queue; the request rises once the port has been idle a
  // cycle with work pending, and completion (grant or timeout) pops the head.
  typedef struct packed {logic rw; logic [7:0] a; logic [7:0] d;} op_t;
  op_t q[$];
  op_t e_bus;
  logic m_on = 0, e_req = 0, e_valid = 0, e_err = 0, m_done, m_tmo, m_nreq;
  logic [7:0] e_rdata = 0;
  int gap = 1, age = 0, occ;
  always @(posedge clk) begin
    #1;
    if (reset) begin
      q.delete();
      m_on = 1; e_req = 0; e_valid = 0; e_rdata = 0; e_err = 0; gap = 1; age = 0;
    end else if (m_on) begin
      m_tmo = 0;
`ifdef BUS_TIMEOUT_EN
      m_tmo = e_req && !bus_grant && age == TMO;
`endif
      m_done  = e_req && (bus_grant || m_tmo);
      e_valid = m_done;
      if (m_done) begin
        e_rdata = (bus_grant && q[0].rw) ? bus_data_in : 8'h00;
        e_err   = !bus_grant;
      end
      occ    = q.size();
      m_nreq = e_req ? !m_done : (gap >= 1 && occ > 0);
      if (m_nreq && !e_req) begin e_bus = q[0]; age = 1; end
      else if (m_nreq) age++;
      gap = m_done ? 0 : (gap < 2 ? gap + 1 : gap);
      if (op_valid && occ < DEPTH) q.push_back({op_rw, op_address, op_wdata});
      if (m_done) void'(q.pop_front());
      e_req = m_nreq;
    end
    if (m_on) begin
      chk("m_op_ready", {7'd0, op_ready}, {7'd0, q.size() < DEPTH});
      chk("m_bus_request", {7'd0, bus_request}, {7'd0, e_req});
      chk("m_resp_valid", {7'd0, resp_valid}, {7'd0, e_valid});
      chk("m_resp_rdata", resp_rdata, e_rdata);
      chk("m_resp_error", {7'd0, resp_error}, {7'd0, e_err});
      if (e_req) begin
        chk("m_bus_rw", {7'd0, bus_rw}, {7'd0, e_bus.rw});
        chk("m_bus_address", bus_address, e_bus.a);
        chk("m_bus_data_out", bus_data_out, e_bus.d);
      end
    end
  end
  task automatic push(input logic rw, input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    op_valid = 1; op_rw = rw; op_address = a; op_wdata = d;
    while (!op_ready && n < 50) begin @(negedge clk); n++; end
    if (n == 50) chk("push_timeout", 8'd0, 8'd1);
    @(negedge clk);
    op_valid = 0;
  endtask
  task automatic wait_req(output int n);
    n = 0;
    while (!bus_request && n < 20) begin @(negedge clk); n++; end
    chk("req_rise", {7'd0, bus_request}, 8'd1);
  endtask
  typedef struct {logic rw; logic [7:0] a, d, din; int gdly; logic [7:0] exp_rdata;} vec_t;
  vec_t vt[6];
  logic [7:0] got[3];
  initial begin
    int n, held;
    vt[0] = '{1'b1, 8'h05, 8'h00, 8'hFF, 3, 8'hFF};
    vt[1] = '{1'b0, 8'h20, 8'h5A, 8'hC3, 0, 8'h00};
    vt[2] = '{1'b1, 8'h80, 8'h11, 8'h00, 1, 8'h00};
    vt[3] = '{1'b1, 8'hFF, 8'h22, 8'hA5, 4, 8'hA5};
    vt[4] = '{1'b0, 8'h00, 8'hFF, 8'hFF, 2, 8'h00};
    vt[5] = '{1'b1, 8'h7E, 8'h00, 8'h01, 0, 8'h01};
    repeat (2) @(negedge clk);
    chk("rst_request", {7'd0, bus_request}, 8'd0);
    chk("rst_resp_valid", {7'd0, resp_valid}, 8'd0);
    chk("rst_op_ready", {7'd0, op_ready}, 8'd1);
    reset = 0;
    @(negedge clk);
    chk("rst_idle_request", {7'd0, bus_request}, 8'd0);
    for (int i = 0; i < 6; i++) begin
      push(vt[i].rw, vt[i].a, vt[i].d);
      wait_req(n);
      repeat (vt[i].gdly) begin
        chk("tbl_hold_addr", bus_address, vt[i].a);
        @(negedge clk);
      end
      chk("tbl_addr", bus_address, vt[i].a);
      chk("tbl_wdata", bus_data_out, vt[i].d);
      chk("tbl_rw", {7'd0, bus_rw}, {7'd0, vt[i].rw});
      bus_grant = 1; bus_data_in = vt[i].din;
      @(negedge clk);
      bus_grant = 0; bus_data_in = 8'h5C;
      chk("tbl_resp_valid", {7'd0, resp_valid}, 8'd1);
      chk("tbl_rdata", resp_rdata, vt[i].exp_rdata);
      chk("tbl_req_drop", {7'd0, bus_request}, 8'd0);
      @(negedge clk);
      chk("tbl_resp_pulse", {7'd0, resp_valid}, 8'd0);
      chk("tbl_rdata_hold", resp_rdata, vt[i].exp_rdata);
      @(negedge clk);
    end
    fork
      begin
        push(1'b0, 8'h10, 8'hAA);
        push(1'b0, 8'h11, 8'hBB);
        chk("full_op_ready", {7'd0, op_ready}, 8'd0);
        push(1'b0, 8'h12, 8'hCC);
      end
      for (int i = 0; i < 3; i++) begin
        wait_req(n);
        if (i > 0) chk("req_gap", n[7:0], 8'd2);
        got[i] = bus_data_out;
        @(negedge clk);
        bus_grant = 1;
        @(negedge clk);
        bus_grant = 0;
        chk("ws_resp_valid", {7'd0, resp_valid}, 8'd1);
        chk("ws_rdata", resp_rdata, 8'h00);
      end
    join
    chk("ws_order0", got[0], 8'hAA);
    chk("ws_order1", got[1], 8'hBB);
    chk("ws_order2", got[2], 8'hCC);
    repeat (3) @(negedge clk);
    bus_grant = 1;
    repeat (2) @(negedge clk);
    chk("spur_resp_valid", {7'd0, resp_valid}, 8'd0);
    chk("spur_op_ready", {7'd0, op_ready}, 8'd1);
    bus_grant = 0;
    push(1'b1, 8'h44, 8'h00);
    wait_req(n);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("mrst_request", {7'd0, bus_request}, 8'd0);
    chk("mrst_resp_valid", {7'd0, resp_valid}, 8'd0);
    repeat (3) @(negedge clk);
    chk("mrst_fifo_empty", {7'd0, bus_request}, 8'd0);
    chk("mrst_no_resp", {7'd0, resp_valid}, 8'd0);
`ifdef BUS_TIMEOUT_EN
    push(1'b1, 8'h66, 8'h00);
    wait_req(n);
    n = 0;
    while (bus_request && n < 20) begin @(negedge clk); n++; end
    chk("tmo_req_cycles", n[7:0], 8'(TMO));
    chk("tmo_resp_valid", {7'd0, resp_valid}, 8'd1);
    chk("tmo_resp_error", {7'd0, resp_error}, 8'd1);
    chk("tmo_rdata", resp_rdata, 8'h00);
    repeat (2) @(negedge clk);
    push(1'b1, 8'h67, 8'h00);
    wait_req(n);
    repeat (TMO - 1) @(negedge clk);
    bus_grant = 1; bus_data_in = 8'h3C;
    @(negedge clk);
    bus_grant = 0;
    chk("tmo_last_grant_valid", {7'd0, resp_valid}, 8'd1);
    chk("tmo_last_grant_error", {7'd0, resp_error}, 8'd0);
    chk("tmo_last_grant_rdata", resp_rdata, 8'h3C);
    repeat (2) @(negedge clk);
`endif
    held = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      reset       = ($urandom_range(0, 299) == 0);
      op_valid    = ($urandom_range(0, 2) != 0);
      op_rw       = 1'($urandom);
      op_address  = 8'($urandom);
      op_wdata    = 8'($urandom);
      held        = bus_request ? held + 1 : 0;
      bus_grant   = bus_request ? ($urandom_range(0, 2) == 0 || held >= 4) : ($urandom_range(0, 9) == 0);
      bus_data_in = 8'($urandom);
    end
    @(negedge clk);
    reset = 0; op_valid = 0; bus_grant = 0;
    repeat (10) begin
      @(negedge clk);
      bus_grant = bus_request;
    end
    bus_grant = 0;
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
